// File: rtl/sram_access_controller.sv
// Splits each 32-bit MEM-stage load/store into two half-word accesses on a 16-bit
// asynchronous SRAM, holding ready low until both halves have completed.
module sram_access_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter int          ADDR_W      = 18,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam int               CNT_W    = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_cnt_next;
    logic              w_latch;

    // Operation latched when the request is accepted; inputs are ignored afterwards.
    logic              r_op_wr;
    logic [ADDR_W-1:0] r_base_addr;
    logic [31:0]       r_wdata;

    logic [31:0]       w_offset;
    logic [ADDR_W-1:0] w_base_addr_in;
    logic              w_req;
    logic              w_last;

    logic              w_op_wr_eff;
    logic [ADDR_W-1:0] w_base_addr_eff;
    logic [31:0]       w_wdata_eff;
    logic              w_in_phase_next;
    logic              w_high_next;
    logic              w_last_next;

    assign w_req  = wr_en | rd_en;
    assign w_last = (r_wait_cnt == CNT_LAST);

    // Low-half SRAM address is word*2; the subtraction wraps silently.
    assign w_offset       = address - BASE_ADDR;
    assign w_base_addr_in = ADDR_W'({w_offset >> 2, 1'b0});

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: defaults are assigned before the case so no path leaves a
    // combinational output unassigned, which would infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_latch         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_next    = S_LOW;
                    w_wait_cnt_next = '0;
                    w_latch         = 1'b1;
                end
            end
            S_LOW: begin
                if (w_last) begin
                    w_state_next    = S_HIGH;
                    w_wait_cnt_next = '0;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (w_last) begin
                    w_state_next    = S_DONE;
                    w_wait_cnt_next = '0;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next    = S_IDLE;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        ready = 1'b0;
        unique case (r_state)
            S_IDLE:  ready = ~w_req;
            S_DONE:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_wr     <= 1'b0;
            r_base_addr <= '0;
            r_wdata     <= '0;
        end else if (w_latch) begin
            r_op_wr     <= wr_en;
            r_base_addr <= w_base_addr_in;
            r_wdata     <= write_data;
        end
    end

    // SRAM pins are registered, so they are derived from the upcoming state;
    // on the accepting edge the request inputs are used before the latch holds them.
    assign w_op_wr_eff     = w_latch ? wr_en          : r_op_wr;
    assign w_base_addr_eff = w_latch ? w_base_addr_in : r_base_addr;
    assign w_wdata_eff     = w_latch ? write_data     : r_wdata;
    assign w_in_phase_next = (w_state_next == S_LOW) || (w_state_next == S_HIGH);
    assign w_high_next     = (w_state_next == S_HIGH);
    assign w_last_next     = (w_wait_cnt_next == CNT_LAST);

    // ------------------------------------------------------------------
    // Registered SRAM interface
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
        end else begin
            // Write strobe drops on the final phase cycle to give address/data hold time.
            sram_we_n  <= ~(w_in_phase_next & w_op_wr_eff & ~w_last_next);
            sram_oe_n  <= ~(w_in_phase_next & ~w_op_wr_eff);
            sram_dq_oe <= w_in_phase_next & w_op_wr_eff;
            if (w_in_phase_next) begin
                sram_addr <= w_high_next ? (w_base_addr_eff | ADDR_W'(1)) : w_base_addr_eff;
                if (w_op_wr_eff) begin
                    sram_dq_o <= w_high_next ? w_wdata_eff[31:16] : w_wdata_eff[15:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read capture on the last cycle of each read phase
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data <= '0;
        end else if (!r_op_wr && w_last) begin
            if (r_state == S_LOW) begin
                read_data[15:0] <= sram_dq_i;
            end else if (r_state == S_HIGH) begin
                read_data[31:16] <= sram_dq_i;
            end
        end
    end

endmodule

// File: tb/tb_sram_access_controller.sv
// Directed and randomized bench for sram_access_controller with a 256-entry
// SRAM model and a transaction-level reference of memory and read_data.
module tb_sram_access_controller;

    localparam int          W    = 2;
    localparam int          AW   = 18;
    localparam logic [31:0] BASE = 32'd1024;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_o;
    logic [15:0]   sram_dq_i;
    logic          sram_dq_oe;
    logic          sram_we_n;
    logic          sram_oe_n;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sram_mem [256];
    logic [15:0] ref_mem  [256];
    logic [31:0] model_rd;

    sram_access_controller #(
        .WAIT_CYCLES(W),
        .ADDR_W     (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .ready     (ready),
        .sram_addr (sram_addr),
        .sram_dq_o (sram_dq_o),
        .sram_dq_i (sram_dq_i),
        .sram_dq_oe(sram_dq_oe),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        return 16'((i * 40503) ^ 32'h1234);
    endfunction

    // Asynchronous SRAM: aliased onto 256 entries, reloaded while reset is high.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i);
        end else if (!sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr[7:0]] <= sram_dq_o;
        end
    end

    assign sram_dq_i = sram_oe_n ? 16'h5A5A : sram_mem[sram_addr[7:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        model_rd = 32'h0;
    endtask

    task automatic idle_cycles(input int n);
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", ready, 1);
            check("idle_we_n", sram_we_n, 1);
            check("idle_oe_n", sram_oe_n, 1);
            check("idle_dq_oe", sram_dq_oe, 0);
            check("idle_read_data", read_data, model_rd);
            @(posedge clk);
            #1;
        end
    endtask

    // Entered #1 after a rising edge with the DUT idle; returns the same way.
    task automatic run_access(input bit wr, input bit rd, input logic [31:0] addr,
                              input logic [31:0] data, input bit junk);
        bit            op_wr;
        bit            in_high;
        int            pos;
        logic [31:0]   word;
        logic [AW-1:0] lo;
        logic [AW-1:0] hi;
        op_wr = wr;
        word  = (addr - BASE) >> 2;
        lo    = AW'({word, 1'b0});
        hi    = AW'({word, 1'b1});
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = data;
        @(negedge clk);
        check("req_ready", ready, 0);
        if (!op_wr) model_rd = {ref_mem[hi[7:0]], ref_mem[lo[7:0]]};
        for (int k = 1; k <= 2 * W + 1; k++) begin
            @(posedge clk);
            #1;
            if (junk) begin
                wr_en      = 1'($urandom);
                rd_en      = 1'($urandom);
                address    = $urandom;
                write_data = $urandom;
            end else begin
                wr_en = 1'b0;
                rd_en = 1'b0;
            end
            @(negedge clk);
            if (k <= 2 * W) begin
                in_high = (k > W);
                pos     = (k - 1) % W;
                check("phase_ready", ready, 0);
                check("phase_addr", 32'(sram_addr), 32'(in_high ? hi : lo));
                check("phase_oe_n", sram_oe_n, op_wr);
                check("phase_dq_oe", sram_dq_oe, op_wr);
                check("phase_we_n", sram_we_n, !(op_wr && pos != W - 1));
                if (op_wr) check("phase_dq_o", 32'(sram_dq_o), 32'(in_high ? data[31:16] : data[15:0]));
            end else begin
                check("done_ready", ready, 1);
                check("done_we_n", sram_we_n, 1);
                check("done_oe_n", sram_oe_n, 1);
                check("done_dq_oe", sram_dq_oe, 0);
                check("done_read_data", read_data, model_rd);
            end
        end
        if (op_wr) begin
            ref_mem[lo[7:0]] = data[15:0];
            ref_mem[hi[7:0]] = data[31:16];
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        bit          r_wr;
        bit          r_rd;
        logic [31:0] r_addr;

        rst        = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        ref_init();

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_read_data", read_data, 0);
        check("rst_addr", 32'(sram_addr), 0);
        check("rst_dq_o", 32'(sram_dq_o), 0);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        idle_cycles(3);

        // Store then load at 1028 (SRAM half-words 2/3)
        run_access(1, 0, 32'd1028, 32'hDEADBEEF, 0);
        run_access(0, 1, 32'd1028, 32'h0, 0);
        check("load_1028_value", model_rd, 32'hDEADBEEF);
        idle_cycles(2);

        // Simultaneous write and read: write wins, read_data unchanged
        run_access(1, 1, 32'd1032, 32'h12345678, 0);
        idle_cycles(1);
        run_access(0, 1, 32'd1032, 32'h0, 1);

        // Address below BASE wraps to the top of the SRAM
        run_access(1, 0, 32'd1020, 32'hCAFEF00D, 1);
        run_access(0, 1, 32'd1021, 32'h0, 0);

        // Reset in cycle 3 of a store
        wr_en      = 1'b1;
        address    = 32'd1036;
        write_data = 32'hA5A5C3C3;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        wr_en = 1'b0;
        #1;
        check("midrst_we_n", sram_we_n, 1);
        check("midrst_dq_oe", sram_dq_oe, 0);
        check("midrst_oe_n", sram_oe_n, 1);
        check("midrst_ready", ready, 1);
        check("midrst_read_data", read_data, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_init();
        @(negedge clk);
        check("post_rst_ready", ready, 1);
        check("post_rst_read_data", read_data, 0);
        @(posedge clk);
        #1;

        // Back-to-back loads
        run_access(0, 1, 32'd1024, 32'h0, 0);
        run_access(0, 1, 32'd1028, 32'h0, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            r_wr   = 1'($urandom);
            r_rd   = r_wr ? 1'($urandom) : 1'b1;
            r_addr = BASE + 32'(4 * $urandom_range(0, 100)) + 32'($urandom_range(0, 3));
            run_access(r_wr, r_rd, r_addr, $urandom, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
